// File: rtl/mem_port_arbiter.sv
// Shares the data-cache request port between an in-order committed-store buffer and pipeline loads.
// Define MEM_ARB_STORE_FWD_EN to forward buffered store data to same-address loads.
module mem_port_arbiter #(
  parameter int STB_DEPTH     = 4,
  parameter int STORE_AGE_MAX = 8,
  parameter int TAG_W         = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_vld,
  input  logic [31:0]                st_addr,
  input  logic [31:0]                st_data,
  output logic                       stb_stall,
  output logic [$clog2(STB_DEPTH):0] stb_count,
  output logic                       stb_ovf,
  input  logic                       ld_req_vld,
  input  logic [31:0]                ld_req_addr,
  input  logic [TAG_W-1:0]           ld_req_tag,
  output logic                       ld_req_rdy,
  output logic                       ld_fwd_hit,
  output logic [31:0]                ld_fwd_data,
  output logic                       mem_req_vld,
  output logic                       mem_req_we,
  output logic [31:0]                mem_req_addr,
  output logic [31:0]                mem_req_wdata,
  output logic [TAG_W-1:0]           mem_req_tag,
  input  logic                       mem_req_rdy
);

  localparam int IW = $clog2(STB_DEPTH);
  localparam int AW = $clog2(STORE_AGE_MAX + 1);
  localparam int DEPTH_M1_I = STB_DEPTH - 1;
  localparam logic [IW:0]   DEPTH    = STB_DEPTH[IW:0];
  localparam logic [IW:0]   DEPTH_M1 = DEPTH_M1_I[IW:0];
  localparam logic [AW-1:0] AGE_MAX  = STORE_AGE_MAX[AW-1:0];

  // Store buffer: pointers carry one extra wrap bit so full and empty differ.
  logic [IW:0]      head;
  logic [IW:0]      tail;
  logic [IW-1:0]    head_idx;
  logic [IW-1:0]    tail_idx;
  logic [31:0]      stb_addr_q [STB_DEPTH];
  logic [31:0]      stb_data_q [STB_DEPTH];
  logic             stb_empty;
  logic             stb_full;
  logic [AW-1:0]    age_cnt;

  // Output request register.
  logic             out_vld;
  logic             out_we;
  logic [31:0]      out_addr;
  logic [31:0]      out_wdata;
  logic [TAG_W-1:0] out_tag;
  logic             out_free;

  logic             store_forced;
  logic             ld_conflict;
  logic             load_win;
  logic             store_win;
  logic [IW-1:0]    scan_idx;
`ifdef MEM_ARB_STORE_FWD_EN
  logic [31:0]      fwd_data;
`endif

  assign head_idx  = head[IW-1:0];
  assign tail_idx  = tail[IW-1:0];
  assign stb_count = tail - head;
  assign stb_empty = (stb_count == '0);
  assign stb_full  = (stb_count == DEPTH);
  assign stb_stall = (stb_count >= DEPTH_M1);

  // Scan oldest to youngest so the last match seen is the youngest store;
  // the output register holding a store is older than every buffer entry.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    ld_conflict = out_vld & out_we & (out_addr == ld_req_addr);
    scan_idx    = '0;
`ifdef MEM_ARB_STORE_FWD_EN
    fwd_data    = out_wdata;
`endif
    for (int i = 0; i < STB_DEPTH; i++) begin
      scan_idx = head_idx + i[IW-1:0];
      if ((i[IW:0] < stb_count) && (stb_addr_q[scan_idx] == ld_req_addr)) begin
        ld_conflict = 1'b1;
`ifdef MEM_ARB_STORE_FWD_EN
        fwd_data    = stb_data_q[scan_idx];
`endif
      end
    end
  end

  assign out_free     = ~out_vld | mem_req_rdy;
  assign store_forced = ~stb_empty & (stb_full | (age_cnt >= AGE_MAX));
  assign load_win     = out_free & ld_req_vld & ~store_forced & ~ld_conflict;
  assign store_win    = out_free & ~stb_empty & ~load_win;

`ifdef MEM_ARB_STORE_FWD_EN
  // A forwarded load never uses the port, so a store may still win in that cycle.
  assign ld_fwd_hit  = ld_req_vld & ld_conflict;
  assign ld_fwd_data = ld_fwd_hit ? fwd_data : 32'h0;
  assign ld_req_rdy  = load_win | ld_fwd_hit;
`else
  assign ld_fwd_hit  = 1'b0;
  assign ld_fwd_data = 32'h0;
  assign ld_req_rdy  = load_win;
`endif

  assign mem_req_vld   = out_vld;
  assign mem_req_we    = out_we;
  assign mem_req_addr  = out_addr;
  assign mem_req_wdata = out_wdata;
  assign mem_req_tag   = out_tag;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      stb_ovf   <= 1'b0;
      age_cnt   <= '0;
      out_vld   <= 1'b0;
      out_we    <= 1'b0;
      out_addr  <= '0;
      out_wdata <= '0;
      out_tag   <= '0;
    end else begin
      if (st_vld) begin
        if (stb_full) stb_ovf <= 1'b1;
        else          tail    <= tail + 1'b1;
      end
      if (store_win) head <= head + 1'b1;

      if (stb_empty || store_win)  age_cnt <= '0;
      else if (age_cnt < AGE_MAX)  age_cnt <= age_cnt + 1'b1;

      if (load_win) begin
        out_vld   <= 1'b1;
        out_we    <= 1'b0;
        out_addr  <= ld_req_addr;
        out_wdata <= '0;
        out_tag   <= ld_req_tag;
      end else if (store_win) begin
        out_vld   <= 1'b1;
        out_we    <= 1'b1;
        out_addr  <= stb_addr_q[head_idx];
        out_wdata <= stb_data_q[head_idx];
        out_tag   <= '0;
      end else if (out_free) begin
        out_vld   <= 1'b0;
      end
    end
  end

  // NOTE: buffer storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (!rst && st_vld && !stb_full) begin
      stb_addr_q[tail_idx] <= st_addr;
      stb_data_q[tail_idx] <= st_data;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a per-cycle vector table, hand-written corner
// sequences, and a store/load scoreboard that checks every accepted cache request.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_STORE_FWD_EN
  localparam logic FWD_EN = 1'b1;
`else
  localparam logic FWD_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        st_vld;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        stb_stall;
  logic [2:0]  stb_count;
  logic        stb_ovf;
  logic        ld_req_vld;
  logic [31:0] ld_req_addr;
  logic [3:0]  ld_req_tag;
  logic        ld_req_rdy;
  logic        ld_fwd_hit;
  logic [31:0] ld_fwd_data;
  logic        mem_req_vld;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_tag;
  logic        mem_req_rdy;

  mem_port_arbiter #(.STB_DEPTH(4), .STORE_AGE_MAX(8), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .st_vld(st_vld), .st_addr(st_addr), .st_data(st_data),
    .stb_stall(stb_stall), .stb_count(stb_count), .stb_ovf(stb_ovf),
    .ld_req_vld(ld_req_vld), .ld_req_addr(ld_req_addr), .ld_req_tag(ld_req_tag),
    .ld_req_rdy(ld_req_rdy), .ld_fwd_hit(ld_fwd_hit), .ld_fwd_data(ld_fwd_data),
    .mem_req_vld(mem_req_vld), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_tag(mem_req_tag), .mem_req_rdy(mem_req_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } st_exp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  tag;
  } ld_exp_t;

  typedef struct {
    logic        st_vld;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        ld_vld;
    logic [31:0] ld_addr;
    logic [3:0]  ld_tag;
    logic        mem_rdy;
    logic        exp_ld_rdy;
    logic [2:0]  exp_cnt;
    logic        exp_vld;
    logic        exp_we;
  } vec_t;

  st_exp_t st_q[$];
  ld_exp_t ld_q[$];
  int      n_tests = 0;
  int      n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: stores and loads each keep their own expected order.
  always @(negedge clk) begin
    st_exp_t se;
    ld_exp_t le;
    if (!rst) begin
      if (mem_req_vld && mem_req_rdy) begin
        n_tests++;
        if (mem_req_we) begin
          if (st_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_extra_store: got addr 0x%0h, required no store", mem_req_addr);
          end else begin
            n_tests--;
            se = st_q.pop_front();
            check("sb_st_addr", mem_req_addr, se.addr);
            check("sb_st_wdata", mem_req_wdata, se.data);
            check("sb_st_tag", {28'h0, mem_req_tag}, 32'h0);
          end
        end else begin
          if (ld_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_extra_load: got addr 0x%0h, required no load", mem_req_addr);
          end else begin
            n_tests--;
            le = ld_q.pop_front();
            check("sb_ld_addr", mem_req_addr, le.addr);
            check("sb_ld_tag", {28'h0, mem_req_tag}, {28'h0, le.tag});
            check("sb_ld_wdata", mem_req_wdata, 32'h0);
          end
        end
      end
      if (ld_req_vld && ld_req_rdy && !ld_fwd_hit)
        ld_q.push_back('{addr: ld_req_addr, tag: ld_req_tag});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    st_vld      = 1'b0;
    st_addr     = '0;
    st_data     = '0;
    ld_req_vld  = 1'b0;
    ld_req_addr = '0;
    ld_req_tag  = '0;
    mem_req_rdy = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    st_q.delete();
    ld_q.delete();
  endtask

  task automatic push_store(input logic [31:0] a, input logic [31:0] d);
    st_vld  = 1'b1;
    st_addr = a;
    st_data = d;
    st_q.push_back('{addr: a, data: d});
  endtask

  task automatic drain(input string name);
    idle();
    repeat (12) step();
    check({name, "_st_q_empty"}, st_q.size(), 0);
    check({name, "_ld_q_empty"}, ld_q.size(), 0);
  endtask

  function automatic vec_t mk(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                              input logic lv, input logic [31:0] la, input logic [3:0] lt,
                              input logic mr, input logic e_rdy, input logic [2:0] e_cnt,
                              input logic e_vld, input logic e_we);
    vec_t v;
    v.st_vld = sv;  v.st_addr = sa;  v.st_data = sd;
    v.ld_vld = lv;  v.ld_addr = la;  v.ld_tag = lt;
    v.mem_rdy = mr; v.exp_ld_rdy = e_rdy; v.exp_cnt = e_cnt;
    v.exp_vld = e_vld; v.exp_we = e_we;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[12];
    logic accepted;

    rst = 1'b1;
    idle();
    do_reset();
    rst = 1'b1;
    step();
    check("rst_mem_req_vld", mem_req_vld, 0);
    check("rst_mem_req_addr", mem_req_addr, 0);
    check("rst_stb_count", stb_count, 0);
    check("rst_stb_stall", stb_stall, 0);
    check("rst_stb_ovf", stb_ovf, 0);
    rst = 1'b0;

    // Per-cycle vectors; expected count/valid/we are after the cycle's edge.
    vecs[0]  = mk(1, 32'h10, 32'h1, 0, 32'h0,  4'd0, 1, 0,      3'd1, 0, 0);
    vecs[1]  = mk(1, 32'h14, 32'h2, 0, 32'h0,  4'd0, 1, 0,      3'd1, 1, 1);
    vecs[2]  = mk(0, 32'h0,  32'h0, 1, 32'h80, 4'd1, 1, 1,      3'd1, 1, 0);
    vecs[3]  = mk(1, 32'h18, 32'h3, 1, 32'h84, 4'd2, 1, 1,      3'd2, 1, 0);
    vecs[4]  = mk(0, 32'h0,  32'h0, 1, 32'h14, 4'd3, 1, FWD_EN, 3'd1, 1, 1);
    vecs[5]  = mk(0, 32'h0,  32'h0, 0, 32'h0,  4'd0, 1, 0,      3'd0, 1, 1);
    vecs[6]  = mk(0, 32'h0,  32'h0, 0, 32'h0,  4'd0, 1, 0,      3'd0, 0, 0);
    vecs[7]  = mk(1, 32'h20, 32'h4, 0, 32'h0,  4'd0, 0, 0,      3'd1, 0, 0);
    vecs[8]  = mk(0, 32'h0,  32'h0, 0, 32'h0,  4'd0, 0, 0,      3'd0, 1, 1);
    vecs[9]  = mk(0, 32'h0,  32'h0, 1, 32'h90, 4'd4, 0, 0,      3'd0, 1, 1);
    vecs[10] = mk(0, 32'h0,  32'h0, 1, 32'h90, 4'd4, 1, 1,      3'd0, 1, 0);
    vecs[11] = mk(0, 32'h0,  32'h0, 0, 32'h0,  4'd0, 1, 0,      3'd0, 0, 0);

    for (int i = 0; i < 12; i++) begin
      st_vld      = vecs[i].st_vld;
      st_addr     = vecs[i].st_addr;
      st_data     = vecs[i].st_data;
      ld_req_vld  = vecs[i].ld_vld;
      ld_req_addr = vecs[i].ld_addr;
      ld_req_tag  = vecs[i].ld_tag;
      mem_req_rdy = vecs[i].mem_rdy;
      if (vecs[i].st_vld) st_q.push_back('{addr: vecs[i].st_addr, data: vecs[i].st_data});
      @(negedge clk);
      check($sformatf("vec%0d_ld_rdy", i), ld_req_rdy, vecs[i].exp_ld_rdy);
      step();
      check($sformatf("vec%0d_count", i), stb_count, vecs[i].exp_cnt);
      check($sformatf("vec%0d_vld", i), mem_req_vld, vecs[i].exp_vld);
      if (vecs[i].exp_vld) check($sformatf("vec%0d_we", i), mem_req_we, vecs[i].exp_we);
    end
    drain("vec");

    // Store drain latency: visible exactly two cycles after st_vld.
    do_reset();
    push_store(32'h100, 32'hAA);
    @(negedge clk);
    check("drain_t0_vld", mem_req_vld, 0);
    step();
    idle();
    @(negedge clk);
    check("drain_t1_vld", mem_req_vld, 0);
    step();
    @(negedge clk);
    check("drain_t2_vld", mem_req_vld, 1);
    check("drain_t2_we", mem_req_we, 1);
    check("drain_t2_addr", mem_req_addr, 32'h100);
    check("drain_t2_wdata", mem_req_wdata, 32'hAA);
    step();
    @(negedge clk);
    check("drain_t3_vld", mem_req_vld, 0);
    drain("drain");

    // Starvation: eight load grants, then the aged store is forced out.
    do_reset();
    push_store(32'h300, 32'h55);
    step();
    st_vld = 1'b0;
    for (int i = 0; i < 9; i++) begin
      ld_req_vld  = 1'b1;
      ld_req_addr = 32'h400 + 32'(4 * i);
      ld_req_tag  = 4'(i);
      @(negedge clk);
      check($sformatf("starve_ld_rdy%0d", i), ld_req_rdy, (i < 8));
      step();
    end
    ld_req_vld = 1'b0;
    @(negedge clk);
    check("starve_store_vld", mem_req_vld, 1);
    check("starve_store_we", mem_req_we, 1);
    check("starve_store_addr", mem_req_addr, 32'h300);
    check("starve_age_cleared", dut.age_cnt, 0);
    drain("starve");

    // Backpressure: held load stays stable, second load waits.
    do_reset();
    mem_req_rdy = 1'b0;
    ld_req_vld  = 1'b1;
    ld_req_addr = 32'h40;
    ld_req_tag  = 4'd5;
    @(negedge clk);
    check("bp_first_rdy", ld_req_rdy, 1);
    step();
    ld_req_addr = 32'h44;
    ld_req_tag  = 4'd6;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d_rdy", k), ld_req_rdy, 0);
      check($sformatf("bp_hold%0d_vld", k), mem_req_vld, 1);
      check($sformatf("bp_hold%0d_we", k), mem_req_we, 0);
      check($sformatf("bp_hold%0d_addr", k), mem_req_addr, 32'h40);
      check($sformatf("bp_hold%0d_tag", k), {28'h0, mem_req_tag}, 32'd5);
      step();
    end
    mem_req_rdy = 1'b1;
    @(negedge clk);
    check("bp_second_rdy", ld_req_rdy, 1);
    step();
    drain("bp");

    // Same-address conflict against two buffered stores.
    do_reset();
    mem_req_rdy = 1'b0;
    push_store(32'h200, 32'h11);
    step();
    push_store(32'h200, 32'h22);
    step();
    st_vld      = 1'b0;
    mem_req_rdy = 1'b1;
    ld_req_vld  = 1'b1;
    ld_req_addr = 32'h200;
    ld_req_tag  = 4'd7;
`ifdef MEM_ARB_STORE_FWD_EN
    @(negedge clk);
    check("conf_fwd_rdy", ld_req_rdy, 1);
    check("conf_fwd_hit", ld_fwd_hit, 1);
    check("conf_fwd_data", ld_fwd_data, 32'h22);
    step();
    ld_req_vld = 1'b0;
`else
    @(negedge clk);
    check("conf_blocked_rdy", ld_req_rdy, 0);
    check("conf_no_fwd", ld_fwd_hit, 0);
    step();
    accepted = 1'b0;
    for (int k = 0; k < 10 && !accepted; k++) begin
      @(negedge clk);
      if (ld_req_rdy) begin
        accepted = 1'b1;
        check("conf_stores_first", st_q.size(), 0);
      end
      step();
    end
    check("conf_ld_accepted", accepted, 1);
    ld_req_vld = 1'b0;
`endif
    drain("conf");

    // Full buffer and overflow with the port stalled.
    do_reset();
    mem_req_rdy = 1'b0;
    begin
      logic [2:0] exp_cnt [6] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
      for (int i = 0; i < 6; i++) begin
        if (i < 5) push_store(32'h500 + 32'(4 * i), 32'hB0 + 32'(i));
        else begin
          st_vld  = 1'b1;
          st_addr = 32'h5FC;
          st_data = 32'hDEAD;
        end
        step();
        check($sformatf("ovf_count%0d", i), stb_count, exp_cnt[i]);
        check($sformatf("ovf_stall%0d", i), stb_stall, (exp_cnt[i] >= 3'd3));
        check($sformatf("ovf_flag%0d", i), stb_ovf, (i == 5));
      end
    end
    st_vld = 1'b0;
    step();
    check("ovf_sticky_idle", stb_ovf, 1);
    drain("ovf");
    check("ovf_sticky_drained", stb_ovf, 1);
    check("ovf_drained_count", stb_count, 0);

    // Reset in the middle of buffered, stalled traffic.
    mem_req_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      st_vld  = 1'b1;
      st_addr = 32'h600 + 32'(4 * i);
      st_data = 32'hC0 + 32'(i);
      step();
    end
    st_vld = 1'b0;
    check("rmid_pre_count", stb_count, 3);
    check("rmid_pre_stall", stb_stall, 1);
    check("rmid_pre_vld", mem_req_vld, 1);
    check("rmid_pre_ovf", stb_ovf, 1);
    rst     = 1'b1;
    st_vld  = 1'b1;
    st_addr = 32'h700;
    st_data = 32'h77;
    step();
    check("rmid_count", stb_count, 0);
    check("rmid_vld", mem_req_vld, 0);
    check("rmid_stall", stb_stall, 0);
    check("rmid_ovf", stb_ovf, 0);
    rst = 1'b0;
    idle();
    st_q.delete();
    ld_q.delete();
    step();
    check("rmid_inflight_dropped", stb_count, 0);
    drain("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
